// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor emulator: answers a host start pulse on the open-drain data wire
// with the 40-bit humidity/temperature frame, optionally with a corrupted checksum.
module dht11_sensor_emu #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int START_MIN_US = 18000,
   parameter int RESP_DLY_US  = 30,
   parameter int RESP_US      = 80,
   parameter int BIT_LOW_US   = 50,
   parameter int ZERO_HIGH_US = 26,
   parameter int ONE_HIGH_US  = 70
) (
   input  logic       clk_i,
   input  logic       rst_i,
   inout  wire        w1_io,
   input  logic [7:0] hum_i,
   input  logic [7:0] temp_i,
   input  logic       err_inj_i,
   output logic       busy_o,
   output logic       frame_done_o,
   output logic       short_start_o
);
   localparam int US_TICKS = CLK_HZ / 1_000_000;
   localparam int US_MAX   = (START_MIN_US > 255) ? START_MIN_US : 255;
   localparam int CW       = $clog2(US_MAX + 1);
   localparam int PW       = (US_TICKS > 1) ? $clog2(US_TICKS) : 1;

   typedef enum logic [3:0] {
      IDLE, HOST_LOW, WAIT_REL, RESP_DLY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
   } state_t;

   state_t        state_q, state_d;
   logic          w1_m, w1_s, w1_s_d;
   logic [PW-1:0] pre_q;
   logic [CW-1:0] us_q;
   logic [CW-1:0] phase_len;
   logic [39:0]   frame_q;
   logic [5:0]    idx_q;
   logic [7:0]    chk;
   logic          drive_low, us_tick, phase_end, fall;
   logic          frame_done_q, short_q;

   assign w1_io = drive_low ? 1'b0 : 1'bz;

   // Two-flop synchroniser; reset to the idle (pulled-up) level so reset never looks like a start.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w1_m   <= 1'b1;
         w1_s   <= 1'b1;
         w1_s_d <= 1'b1;
      end else begin
         w1_m   <= w1_io;
         w1_s   <= w1_m;
         w1_s_d <= w1_s;
      end
   end

   assign fall    = w1_s_d & ~w1_s;
   assign us_tick = (pre_q == PW'(US_TICKS - 1));
   assign chk     = (hum_i + temp_i) ^ {7'b0, err_inj_i};

   always_comb begin
      phase_len = '0;
      case (state_q)
         HOST_LOW:  phase_len = CW'(START_MIN_US);
         RESP_DLY:  phase_len = CW'(RESP_DLY_US);
         RESP_LOW:  phase_len = CW'(RESP_US);
         RESP_HIGH: phase_len = CW'(RESP_US);
         BIT_LOW:   phase_len = CW'(BIT_LOW_US);
         BIT_HIGH:  phase_len = frame_q[idx_q] ? CW'(ONE_HIGH_US) : CW'(ZERO_HIGH_US);
         END_LOW:   phase_len = CW'(BIT_LOW_US);
         default:   phase_len = '0;
      endcase
   end

   assign phase_end = us_tick && (us_q == phase_len - 1'b1);

   // Timebase restarts on every state change so each phase is exactly N microseconds long.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pre_q <= '0;
         us_q  <= '0;
      end else if (state_d != state_q) begin
         pre_q <= '0;
         us_q  <= '0;
      end else if (us_tick) begin
         pre_q <= '0;
         if (us_q != CW'(US_MAX))
            us_q <= us_q + 1'b1;
      end else begin
         pre_q <= pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (fall) state_d = HOST_LOW;
         HOST_LOW: begin
            if (phase_end)
               state_d = WAIT_REL;
            else if (w1_s)
               state_d = IDLE;
         end
         WAIT_REL:  if (w1_s) state_d = RESP_DLY;
         RESP_DLY:  if (phase_end) state_d = RESP_LOW;
         RESP_LOW:  if (phase_end) state_d = RESP_HIGH;
         RESP_HIGH: if (phase_end) state_d = BIT_LOW;
         BIT_LOW:   if (phase_end) state_d = BIT_HIGH;
         BIT_HIGH:  if (phase_end) state_d = (idx_q == 6'd0) ? END_LOW : BIT_LOW;
         END_LOW:   if (phase_end) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      drive_low = 1'b0;
      busy_o    = 1'b0;
      case (state_q)
         RESP_LOW, BIT_LOW, END_LOW: begin
            drive_low = 1'b1;
            busy_o    = 1'b1;
         end
         RESP_DLY, RESP_HIGH, BIT_HIGH: busy_o = 1'b1;
         default: begin
            drive_low = 1'b0;
            busy_o    = 1'b0;
         end
      endcase
   end

   // Frame is captured once at host release; later input changes wait for the next start.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         frame_q      <= '0;
         idx_q        <= '0;
         frame_done_q <= 1'b0;
         short_q      <= 1'b0;
      end else begin
         if (state_q == WAIT_REL && w1_s)
            frame_q <= {hum_i, 8'h00, temp_i, 8'h00, chk};
         if (state_q == RESP_HIGH && phase_end)
            idx_q <= 6'd39;
         else if (state_q == BIT_HIGH && phase_end && idx_q != 6'd0)
            idx_q <= idx_q - 1'b1;
         frame_done_q <= (state_q == END_LOW) && phase_end;
         short_q      <= (state_q == HOST_LOW) && !phase_end && w1_s;
      end
   end

   assign frame_done_o  = frame_done_q;
   assign short_start_o = short_q;
endmodule

// File: tb/tb_dht11_sensor_emu.sv
`timescale 1ns/1ps
// Bench for dht11_sensor_emu: issues host start pulses, decodes returned frames
// from the wire and scores them against a frame model held in a queue.
module tb_dht11_sensor_emu;
   localparam int CLK_HZ       = 1_000_000;
   localparam int START_MIN_US = 100;
   localparam int RESP_DLY_US  = 30;
   localparam int RESP_US      = 80;
   localparam int BIT_LOW_US   = 50;
   localparam int ZERO_HIGH_US = 26;
   localparam int ONE_HIGH_US  = 70;
   localparam int IN_LAT       = 3;
   localparam int SEG_LIMIT    = 500;
   localparam int FRAME_LIMIT  = 8000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       host_low = 1'b0;
   logic       err_inj = 1'b0;
   logic [7:0] hum = 8'd0;
   logic [7:0] temp = 8'd0;
   logic       busy, frame_done, short_start;
   wire        w1;

   assign w1 = host_low ? 1'b0 : 1'bz;
   pullup (w1);

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int rel_cyc = 0;
   int fd_cnt = 0, ss_cnt = 0, dut_low_cnt = 0, busy_cnt = 0;
   int fd_base = 0, busy_base = 0;
   bit rst_evt = 1'b0;
   logic [39:0] sb_q[$];

   dht11_sensor_emu #(
      .CLK_HZ(CLK_HZ), .START_MIN_US(START_MIN_US), .RESP_DLY_US(RESP_DLY_US),
      .RESP_US(RESP_US), .BIT_LOW_US(BIT_LOW_US), .ZERO_HIGH_US(ZERO_HIGH_US),
      .ONE_HIGH_US(ONE_HIGH_US)
   ) dut (
      .clk_i(clk), .rst_i(rst), .w1_io(w1), .hum_i(hum), .temp_i(temp),
      .err_inj_i(err_inj), .busy_o(busy), .frame_done_o(frame_done),
      .short_start_o(short_start)
   );

   always #500 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(posedge rst) rst_evt = 1'b1;

   // Event counters sampled just after each active edge.
   always begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) fd_cnt++;
      if (short_start === 1'b1) ss_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (w1 === 1'b0 && !host_low) dut_low_cnt++;
   end

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [39:0] ref_frame(input logic [7:0] h, input logic [7:0] t, input logic e);
      int sum;
      logic [7:0] c;
      sum = int'(h) + int'(t);
      c = 8'(sum % 256);
      if (e) c = c ^ 8'h01;
      return {h, 8'h00, t, 8'h00, c};
   endfunction

   function automatic int ref_busy_len(input logic [39:0] f);
      int ones;
      ones = $countones(f);
      return RESP_DLY_US + 2 * RESP_US + 41 * BIT_LOW_US + ones * ONE_HIGH_US + (40 - ones) * ZERO_HIGH_US;
   endfunction

   task automatic host_pulse(input int us);
      @(negedge clk);
      host_low = 1'b1;
      repeat (us) @(negedge clk);
      host_low = 1'b0;
      rel_cyc = cyc;
   endtask

   task automatic apply_stimulus(input logic [7:0] h, input logic [7:0] t, input logic e, input int low_us);
      hum = h;
      temp = t;
      err_inj = e;
      sb_q.push_back(ref_frame(h, t, e));
      fd_base = fd_cnt;
      busy_base = busy_cnt;
      host_pulse(low_us);
   endtask

   task automatic wait_done(input string name, input logic [39:0] exp);
      int n;
      n = 0;
      while (frame_done !== 1'b1 && n < FRAME_LIMIT) begin
         sample();
         n++;
      end
      check_output({name, "_done_seen"}, longint'(n < FRAME_LIMIT), 1);
      check_output({name, "_busy_after"}, longint'(busy), 0);
      repeat (3) sample();
      check_output({name, "_done_pulses"}, fd_cnt - fd_base, 1);
      check_output({name, "_busy_span"}, busy_cnt - busy_base, ref_busy_len(exp));
   endtask

   task automatic run_len(input logic lvl, output int n, output bit ab);
      n = 0;
      ab = 1'b0;
      while (n < SEG_LIMIT) begin
         if (rst_evt) begin
            ab = 1'b1;
            return;
         end
         if (w1 !== lvl) return;
         n++;
         sample();
      end
   endtask

   task automatic decode_and_score();
      int seg[84];
      int dly, bad_lo, bad_hi, exp_hi;
      bit ab;
      logic [39:0] got, exp;
      rst_evt = 1'b0;
      dly = 0;
      got = '0;
      sample();
      for (int k = 0; k < 84; k++) begin
         run_len((k == 0 || (k % 2 == 0 && k < 83)) ? 1'b1 : 1'b0, seg[k], ab);
         if (!ab && seg[k] >= SEG_LIMIT) begin
            check_output("segment_timeout", k, -1);
            ab = 1'b1;
         end
         if (ab) begin
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            return;
         end
         if (k == 0) dly = cyc - rel_cyc;
      end
      bad_lo = 0;
      bad_hi = 0;
      for (int i = 0; i < 40; i++) begin
         got[39 - i] = (seg[4 + 2 * i] > (ZERO_HIGH_US + ONE_HIGH_US) / 2);
         exp_hi = got[39 - i] ? ONE_HIGH_US : ZERO_HIGH_US;
         if (seg[3 + 2 * i] != BIT_LOW_US) bad_lo++;
         if (seg[4 + 2 * i] != exp_hi) bad_hi++;
      end
      check_output("resp_delay", dly, RESP_DLY_US + IN_LAT);
      check_output("resp_low", seg[1], RESP_US);
      check_output("resp_high", seg[2], RESP_US);
      check_output("bit_low_bad_count", bad_lo, 0);
      check_output("bit_high_bad_count", bad_hi, 0);
      check_output("end_low", seg[83], BIT_LOW_US);
      if (sb_q.size() == 0) begin
         check_output("unexpected_frame", longint'(got), -1);
      end else begin
         exp = sb_q.pop_front();
         check_output("frame", longint'(got), longint'(exp));
      end
   endtask

   initial begin : monitor
      forever begin
         @(posedge busy);
         decode_and_score();
      end
   end

   task automatic short_start_test();
      int ss0, dl0, b0;
      ss0 = ss_cnt;
      dl0 = dut_low_cnt;
      b0 = busy_cnt;
      host_pulse(60);
      repeat (20) sample();
      check_output("short_pulse_count", ss_cnt - ss0, 1);
      check_output("short_no_drive", dut_low_cnt - dl0, 0);
      check_output("short_busy", busy_cnt - b0, 0);
   endtask

   task automatic reset_mid_frame_test();
      int falls, n;
      logic prev;
      apply_stimulus(8'($urandom), 8'($urandom), 1'b0, 150);
      falls = 0;
      n = 0;
      prev = 1'b1;
      while (falls < 14 && n < FRAME_LIMIT) begin
         sample();
         if (prev === 1'b1 && w1 === 1'b0) falls++;
         prev = w1;
         n++;
      end
      check_output("rst_reached_bit12", falls, 14);
      rst = 1'b1;
      #1;
      check_output("rst_line_released", longint'(w1 === 1'b1), 1);
      check_output("rst_busy", longint'(busy), 0);
      check_output("rst_done_low", longint'(frame_done), 0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (10) sample();
   endtask

   task automatic stability_test(input logic [7:0] h, input logic [7:0] t);
      int n, phase;
      logic prev;
      apply_stimulus(h, t, 1'b0, 150);
      n = 0;
      phase = 0;
      prev = 1'b1;
      while (phase < 2 && n < FRAME_LIMIT) begin
         sample();
         if (phase == 0 && prev === 1'b1 && w1 === 1'b0) phase = 1;
         else if (phase == 1 && prev === 1'b0 && w1 === 1'b1) phase = 2;
         prev = w1;
         n++;
      end
      check_output("stab_reached_resp_high", phase, 2);
      hum = ~h;
      wait_done("stability", ref_frame(h, t, 1'b0));
   endtask

   initial begin : stimulus
      logic [7:0] h, t;
      logic e;
      int n;
      repeat (3) @(negedge clk);
      check_output("reset_busy", longint'(busy), 0);
      check_output("reset_done", longint'(frame_done), 0);
      check_output("reset_short", longint'(short_start), 0);
      check_output("reset_line", longint'(w1 === 1'b1), 1);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      apply_stimulus(8'd45, 8'd23, 1'b0, 150);
      wait_done("accept", ref_frame(8'd45, 8'd23, 1'b0));
      repeat (10) sample();

      short_start_test();

      apply_stimulus(8'hFF, 8'h02, 1'b0, 150);
      wait_done("wrap", ref_frame(8'hFF, 8'h02, 1'b0));
      repeat (10) sample();

      apply_stimulus(8'd10, 8'd20, 1'b1, 150);
      n = 0;
      while (busy !== 1'b1 && n < FRAME_LIMIT) begin
         sample();
         n++;
      end
      err_inj = 1'b0;
      wait_done("fault", ref_frame(8'd10, 8'd20, 1'b1));
      repeat (10) sample();

      reset_mid_frame_test();
      apply_stimulus(8'd61, 8'd19, 1'b0, 120);
      wait_done("after_reset", ref_frame(8'd61, 8'd19, 1'b0));
      repeat (10) sample();

      stability_test(8'($urandom), 8'($urandom));
      repeat (10) sample();

      for (int i = 0; i < 3; i++) begin
         h = 8'($urandom);
         t = 8'($urandom);
         e = 1'($urandom_range(0, 1));
         apply_stimulus(h, t, e, $urandom_range(110, 200));
         wait_done("random", ref_frame(h, t, e));
         repeat ($urandom_range(5, 30)) sample();
      end

      repeat (10) sample();
      check_output("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dht11_sensor_emu.md
Name: dht11_sensor_emu

Overview:
- Emulates a DHT11 humidity/temperature sensor, i.e. the responder end of the single-wire DHT11 protocol.
- Waits for a host start pulse on the open-drain data wire, then transmits the 40-bit frame: humidity int, humidity dec, temperature int, temperature dec, checksum.
- Used in board loopback and simulation benches to exercise the DHT11 host reader without a physical sensor.
- Also provides checksum fault injection.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; US_TICKS = CLK_HZ/1_000_000 cycles per microsecond (integer).
- START_MIN_US, 18000, minimum host low time accepted as a valid start request.
- RESP_DLY_US, 30, delay from host release to sensor response.
- RESP_US, 80, duration of the response low phase and of the response high phase.
- BIT_LOW_US, 50, low preamble of each bit and of the end-of-frame low.
- ZERO_HIGH_US, 26, high time encoding a 0.
- ONE_HIGH_US, 70, high time encoding a 1.

Ports:
- clk_i, input, 1, system clock.
- rst_i, input, 1, asynchronous active-high reset.
- w1_io, inout, 1, DHT11 data wire; driven 0 or high-Z only (external pull-up).
- hum_i, input, 8, humidity integer byte to report.
- temp_i, input, 8, temperature integer byte to report.
- err_inj_i, input, 1, when 1 at frame latch, checksum bit 0 is inverted.
- busy_o, output, 1, high from a valid start detection until the frame ends.
- frame_done_o, output, 1, one-cycle pulse at end of frame.
- short_start_o, output, 1, one-cycle pulse when a host low pulse shorter than START_MIN_US is rejected.

Behaviour:
- Reset (async, rst_i=1): line released (Z), state IDLE, all counters 0, busy_o=0, frame_done_o=0, short_start_o=0.
- Reset asserted mid-frame: line released immediately, asynchronously.
- Input path: w1_io passes through a 2-flop synchronizer (w1_s); edge detection uses w1_s. Input-to-decision latency is 2 cycles.
- Timebase:
  - Microsecond prescaler counts 0..US_TICKS-1.
  - Prescaler and µs counter clear on every state entry, so an N µs phase lasts exactly N*US_TICKS clk cycles.
  - Drive transitions occur on the state-change clock edge.
- Drive: internal drive_low; w1_io = 0 when drive_low, else Z.
- State machine:
  - IDLE: released. w1_s falling edge -> HOST_LOW.
  - HOST_LOW: released, counting µs.
    - w1_s high before START_MIN_US -> pulse short_start_o, back to IDLE.
    - Count reaches START_MIN_US -> WAIT_REL. The counter saturates there.
  - WAIT_REL: released. w1_s high ->
    - latch frame = {hum_i, 8'h00, temp_i, 8'h00, chk};
    - chk = (hum_i + temp_i) mod 256, XOR 8'h01 when err_inj_i=1;
    - set busy_o=1;
    - go to RESP_DLY.
  - RESP_DLY: released RESP_DLY_US -> RESP_LOW.
  - RESP_LOW: drive 0 for RESP_US -> RESP_HIGH.
  - RESP_HIGH: released RESP_US -> BIT_LOW, bit index 39.
  - BIT_LOW: drive 0 for BIT_LOW_US -> BIT_HIGH.
  - BIT_HIGH: released ONE_HIGH_US if frame[idx]=1, else ZERO_HIGH_US.
    - idx>0: decrement idx -> BIT_LOW.
    - idx=0 -> END_LOW.
  - END_LOW: drive 0 for BIT_LOW_US -> IDLE. Release line, busy_o=0, pulse frame_done_o.
- Bit order: MSB of humidity first; checksum last. Frame is latched once; input changes during a frame have no effect until the next start.
- From RESP_DLY through END_LOW, w1_s is ignored. Host contention during the frame does not abort it.
- Back-to-back: a new start is accepted only from IDLE. The first w1_s low after frame_done_o begins a new HOST_LOW measurement.
- Widths:
  - µs counter is wide enough for max(START_MIN_US, 255).
  - Checksum is an 8-bit wrap-around sum.

Test Plan:
- Start accept (CLK_HZ=1_000_000, START_MIN_US=100 for sim): host drives low 150 µs, releases; hum_i=8'd45, temp_i=8'd23.
  - Bench decodes 40 bits 0x2D,0x00,0x17,0x00,0x44.
  - Response low begins exactly 30 µs after release.
  - frame_done_o pulses once; busy_o spans the frame.
- Short start: host low 60 µs then release -> short_start_o single pulse, line never driven, busy_o stays 0.
- Bit timing and wrap: hum_i=8'hFF, temp_i=8'h02.
  - Checksum 0x01.
  - Every 1-bit high measures 70 µs and every 0-bit 26 µs.
  - Every low preamble measures 50 µs.
- Fault injection: err_inj_i=1, hum_i=10, temp_i=20 -> checksum byte 0x1F. Deasserting err_inj_i after the latch does not change the frame.
- Reset mid-frame: assert rst_i during bit 12 low phase.
  - w1_io is Z in the same cycle; busy_o=0.
  - The next valid start produces a complete, correct frame.
- Data stability: change hum_i during RESP_HIGH -> transmitted humidity equals the value latched at host release.
